// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
// Holds the active-low segment pattern type, the all-dark pattern and the hex glyph table.
// Pattern bit order is {dp,g,f,e,d,c,b,a}; a 0 lights the segment.
package sseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SSEG_OFF = 8'hFF;

  // Glyphs for 0-F with dp dark; index with the hex value.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Display bus between a digit source and the scan multiplexer.
// Carries frame inputs (hex, dp, blank, lzs, bright) and pin outputs (ldsel, sseg_n, frame_tick).
// master = source/observer side, slave = multiplexer side.
interface sseg_scan_mux_if #(
  parameter int N_DIGITS = 4,
  parameter int PWM_BITS = 4
);
  import sseg_pkg::*;

  logic [4*N_DIGITS-1:0] i_hex;
  logic [N_DIGITS-1:0]   i_dp;
  logic [N_DIGITS-1:0]   i_blank;
  logic                  i_lzs;
  logic [PWM_BITS-1:0]   i_bright;
  logic [N_DIGITS-1:0]   o_ldsel;
  seg_t                  o_sseg_n;
  logic                  o_frame_tick;

  modport master (
    output i_hex, i_dp, i_blank, i_lzs, i_bright,
    input  o_ldsel, o_sseg_n, o_frame_tick
  );

  modport slave (
    input  i_hex, i_dp, i_blank, i_lzs, i_bright,
    output o_ldsel, o_sseg_n, o_frame_tick
  );

endinterface

// File: rtl/sseg_glyph_dec.sv
// Hex digit plus decimal point to active-low segment pattern.
// Ports: hex (4-bit value), dp (1 = lit), seg_n ({dp,g,f,e,d,c,b,a}, active-low).
// Purely combinational, no state, no backpressure.
module sseg_glyph_dec
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output seg_t       seg_n
);

  assign seg_n = {~dp, HEX_GLYPH[hex][6:0]};

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver: scans N_DIGITS digits, SCAN_DIV cycles each.
// Ports: i_clk, i_reset (async, active-high), bus (slave modport: frame inputs in, ldsel/sseg_n/frame_tick out).
// Latency: pins lag the scan state by one registered cycle; inputs are frame-snapshotted, no backpressure.
// Optional PWM dimming from i_bright is built only when SSEG_SCAN_DIMMING_EN is defined.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  sseg_scan_mux_if.slave bus
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  first_clk;
  logic                  slot_wrap;
  logic                  snap_en;

  logic [4*N_DIGITS-1:0] snap_hex;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_blank;
  logic                  snap_lzs;

  logic [N_DIGITS-1:0]   supp;
  logic                  zero_run;
  logic                  pwm_on;
  logic [3:0]            cur_hex;
  seg_t                  glyph;
  logic [N_DIGITS-1:0]   ldsel_d;
  seg_t                  sseg_d;

  logic [N_DIGITS-1:0]   ldsel_q;
  seg_t                  sseg_q;
  logic                  tick_q;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  // Snapshot on the last-digit-to-digit-0 wrap, and once right after reset so
  // the first frame never runs on the reset-time (all blanked) snapshot.
  assign snap_en   = first_clk | (slot_wrap & (idx == IDX_LAST));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_cnt   <= '0;
      idx        <= '0;
      first_clk  <= 1'b1;
      snap_hex   <= '0;
      snap_dp    <= '0;
      snap_blank <= '1;
      snap_lzs   <= 1'b0;
      ldsel_q    <= '0;
      sseg_q     <= SSEG_OFF;
      tick_q     <= 1'b0;
    end else begin
      slot_cnt  <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      first_clk <= 1'b0;
      if (snap_en) begin
        snap_hex   <= bus.i_hex;
        snap_dp    <= bus.i_dp;
        snap_blank <= bus.i_blank;
        snap_lzs   <= bus.i_lzs;
      end
      ldsel_q <= ldsel_d;
      sseg_q  <= sseg_d;
      tick_q  <= snap_en;
    end
  end

`ifdef SSEG_SCAN_DIMMING_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] snap_bright;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pwm_cnt     <= '0;
      snap_bright <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (snap_en) begin
        snap_bright <= bus.i_bright;
      end
    end
  end

  // All-ones means fully on; otherwise the counter can never reach the level.
  assign pwm_on = (&snap_bright) | (pwm_cnt < snap_bright);
`else
  assign pwm_on = 1'b1;
`endif

  // Leading-zero suppression walks down from the top digit; the first nonzero
  // value or lit dp ends the run for itself and everything below it.
  always_comb begin
    supp     = '0;
    zero_run = snap_lzs;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if ((snap_hex[4*k +: 4] != 4'h0) || snap_dp[k]) begin
        zero_run = 1'b0;
      end
      supp[k] = zero_run;
    end
  end

  assign cur_hex = snap_hex[{idx, 2'b00} +: 4];

  sseg_glyph_dec u_glyph (
    .hex   (cur_hex),
    .dp    (snap_dp[idx]),
    .seg_n (glyph)
  );

  // Slot position 0 is the dead-time cycle after every index change.
  always_comb begin
    ldsel_d = '0;
    sseg_d  = SSEG_OFF;
    if (slot_cnt != '0) begin
      ldsel_d[idx] = 1'b1;
      if (!snap_blank[idx] && !supp[idx] && pwm_on) begin
        sseg_d = glyph;
      end
    end
  end

  assign bus.o_ldsel      = ldsel_q;
  assign bus.o_sseg_n     = sseg_q;
  assign bus.o_frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
module tb_sseg_scan_mux;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int PB    = 4;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] s_hex    = 16'h0;
  logic [3:0]  s_dp     = 4'h0;
  logic [3:0]  s_blank  = 4'h0;
  logic        s_lzs    = 1'b0;
  logic [3:0]  s_bright = 4'hF;

  sseg_scan_mux_if #(.N_DIGITS(ND), .PWM_BITS(PB)) bus ();

  assign bus.i_hex    = s_hex;
  assign bus.i_dp     = s_dp;
  assign bus.i_blank  = s_blank;
  assign bus.i_lzs    = s_lzs;
  assign bus.i_bright = s_bright;

  sseg_scan_mux #(.N_DIGITS(ND), .SCAN_DIV(SD), .PWM_BITS(PB)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;   // rising edges since reset release

  // reference snapshot as the model sees it
  logic [15:0] m_hex    = 16'h0;
  logic [3:0]  m_dp     = 4'h0;
  logic [3:0]  m_blank  = 4'hF;
  logic        m_lzs    = 1'b0;
  logic [3:0]  m_bright = 4'h0;
  logic [7:0]  glyph_tab [16];

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
    int          dig;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %h, want %h", nm, t, act, exp);
    end
  endtask

  function automatic bit suppressed(input int d);
    if (!m_lzs || d == 0) return 1'b0;
    for (int j = d; j < ND; j++) begin
      if (m_hex[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit pwm_lit(input int u);
`ifdef SSEG_SCAN_DIMMING_EN
    return (m_bright == 4'hF) || ((u % 16) < int'(m_bright));
`else
    return (u >= 0);
`endif
  endfunction

  // One clock: predict the pins from the scan position of the previous
  // cycle, then take the model snapshot if this edge is a frame boundary.
  task automatic step();
    int u, dig;
    logic [3:0] e_ldsel;
    logic [7:0] e_sseg, gt;
    logic e_tick;
    @(posedge clk);
    t++;
    u = t - 1;
    e_ldsel = 4'h0;
    e_sseg  = 8'hFF;
    if (u % SD != 0) begin
      dig     = (u / SD) % ND;
      e_ldsel = 4'b0001 << dig;
      if (!m_blank[dig] && !suppressed(dig) && pwm_lit(u)) begin
        gt     = glyph_tab[m_hex[4*dig +: 4]];
        e_sseg = {~m_dp[dig], gt[6:0]};
      end
    end
    e_tick = (t == 1) || (t % FRAME == 0);
    if (e_tick) begin
      m_hex = s_hex; m_dp = s_dp; m_blank = s_blank; m_lzs = s_lzs; m_bright = s_bright;
    end
    #1;
    chk("ldsel", 32'(bus.o_ldsel), 32'(e_ldsel));
    chk("sseg", 32'(bus.o_sseg_n), 32'(e_sseg));
    chk("tick", 32'(bus.o_frame_tick), 32'(e_tick));
  endtask

  task automatic align_frame();
    do step(); while (t % FRAME != 0);
  endtask

  initial begin
    int cnt, exp_cnt;
    logic [3:0] br;
    glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vt.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 0, 8'h99});
    vt.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 1, 8'hB0});
    vt.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 2, 8'hA4});
    vt.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 3, 8'hF9});
    vt.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 3, 8'hFF});
    vt.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 2, 8'hFF});
    vt.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 1, 8'h92});
    vt.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 0, 8'hC0});
    vt.push_back('{16'h0050, 4'h8, 4'h0, 1'b1, 3, 8'h40});
    vt.push_back('{16'h0050, 4'h8, 4'h0, 1'b1, 2, 8'hC0});
    vt.push_back('{16'h0050, 4'h0, 4'h0, 1'b0, 3, 8'hC0});
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 0, 8'hC0});
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 1, 8'hFF});
    vt.push_back('{16'h1234, 4'h0, 4'h2, 1'b0, 1, 8'hFF});
    vt.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 0, 8'hA1});
    vt.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 1, 8'hC6});
    vt.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 2, 8'h83});
    vt.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 3, 8'h88});
    vt.push_back('{16'h00EF, 4'h1, 4'h0, 1'b0, 0, 8'h0E});
    vt.push_back('{16'h00EF, 4'h1, 4'h0, 1'b0, 1, 8'h86});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ldsel", 32'(bus.o_ldsel), 32'h0);
    chk("rst_sseg", 32'(bus.o_sseg_n), 32'hFF);
    chk("rst_tick", 32'(bus.o_frame_tick), 32'h0);
    s_hex = 16'h1234;
    @(negedge clk);
    rst = 1'b0;
    t   = 0;
    repeat (40) step();

    // table vectors, each applied at a frame boundary
    for (int i = 0; i < vt.size(); i++) begin
      s_hex = vt[i].hex; s_dp = vt[i].dp; s_blank = vt[i].blank;
      s_lzs = vt[i].lzs; s_bright = 4'hF;
      align_frame();
      repeat (vt[i].dig * SD + 2) step();
      chk($sformatf("vec%0d_sseg", i), 32'(bus.o_sseg_n), 32'(vt[i].exp));
      chk($sformatf("vec%0d_ldsel", i), 32'(bus.o_ldsel), 32'(4'b0001 << vt[i].dig));
    end

    // frame coherency: change mid-frame while digit 1 is on the pins
    s_hex = 16'h1234; s_dp = 4'h0; s_blank = 4'h0; s_lzs = 1'b0; s_bright = 4'hF;
    align_frame();
    repeat (6) step();
    s_hex = 16'hABCD;
    repeat (5) step();
    chk("coh_d2_old", 32'(bus.o_sseg_n), 32'hA4);
    repeat (4) step();
    chk("coh_d3_old", 32'(bus.o_sseg_n), 32'hF9);
    step();
    chk("coh_tick", 32'(bus.o_frame_tick), 32'h1);
    repeat (2) step();
    chk("coh_d0_new", 32'(bus.o_sseg_n), 32'hA1);

    // brightness: lit cycles over one aligned frame
    s_hex = 16'h8888;
    for (int b = 0; b < 3; b++) begin
      br = (b == 0) ? 4'hF : ((b == 1) ? 4'h0 : 4'h4);
`ifdef SSEG_SCAN_DIMMING_EN
      exp_cnt = (b == 0) ? 12 : ((b == 1) ? 0 : 3);
`else
      exp_cnt = 12;
`endif
      s_bright = br;
      align_frame();
      cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (bus.o_sseg_n != 8'hFF) cnt++;
      end
      chk($sformatf("dim_b%0d_lit", br), 32'(cnt), 32'(exp_cnt));
    end

    // reset mid-slot of digit 2
    s_bright = 4'hF;
    align_frame();
    repeat (11) step();
    chk("pre_rst_lit", 32'(bus.o_sseg_n), 32'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ldsel", 32'(bus.o_ldsel), 32'h0);
    chk("async_rst_sseg", 32'(bus.o_sseg_n), 32'hFF);
    chk("async_rst_tick", 32'(bus.o_frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t   = 0;
    step();
    chk("post_rst_tick", 32'(bus.o_frame_tick), 32'h1);
    step();
    chk("post_rst_d0", 32'(bus.o_ldsel), 32'h1);
    repeat (30) step();

    // randomized inputs against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int d = 0; d < ND; d++) begin
          s_hex[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        s_dp     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        s_blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        s_lzs    = 1'($urandom_range(0, 1));
        s_bright = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 100000: clock cycles per digit slot, minimum 2.
REQ-003 Parameter PWM_BITS, default 4: brightness resolution in bits.
REQ-004 i_clk  in  1: the only clock, rising edge.
REQ-005 i_reset  in  1: asynchronous, active-high reset.
REQ-006 i_hex  in  4*N_DIGITS: digit values; digit k is bits [4k+3:4k], and digit 0 is the rightmost digit.
REQ-007 i_dp  in  N_DIGITS: decimal point request, one bit per digit, 1 = lit.
REQ-008 i_blank  in  N_DIGITS: forces the digit dark, one bit per digit.
REQ-009 i_lzs  in  1: enables leading-zero suppression.
REQ-010 i_bright  in  PWM_BITS: duty level; 0 = dark, all-ones = full on.
REQ-011 o_ldsel  out  N_DIGITS: one-hot digit enable, active-high.
REQ-012 o_sseg_n  out  8: segment drive {dp,g,f,e,d,c,b,a}, active-low.
REQ-013 o_frame_tick  out  1: one-cycle pulse on each frame snapshot.

Function
REQ-014 slot_cnt shall count 0..SCAN_DIV-1 every cycle and wrap to 0.
REQ-015 The digit index shall advance on the slot_cnt wrap, from N_DIGITS-1 to 0, giving exactly SCAN_DIV cycles per digit.
REQ-016 Frame snapshot: i_hex, i_dp, i_blank, i_lzs and i_bright shall be registered together only when the index wraps N_DIGITS-1 to 0, or on the first clock after reset release.
- o_frame_tick is high in the cycle after each snapshot.
- Input changes mid-frame never appear until the next frame.
REQ-017 All outputs shall be registered, with one cycle latency from the index/PWM state to the pins.
REQ-018 Leading-zero suppression: with lzs active, a digit k>0 shall be dark when it and every higher digit have value 0 and dp=0.
- Digit 0 is never suppressed.
- A nonzero digit, or a digit with dp set, stops suppression for itself and all lower digits.
REQ-019 A blanked or suppressed digit shall drive o_sseg_n=8'hFF, including dp, while o_ldsel stays one-hot.
REQ-020 Hex 0-F shall decode to standard seven-segment glyphs (A, b, C, d, E, F for letters); the dp bit comes from the snapshot dp.
REQ-021 o_ldsel shall never have more than one bit set.
- On every index change, o_ldsel and o_sseg_n shall be 0 / 8'hFF for exactly one cycle (dead-time anti-ghosting) before the new digit drives.

Reset
REQ-022 While i_reset is high: slot_cnt=0, index=0, PWM counter=0, snapshot blank=all ones, o_ldsel=0, o_sseg_n=8'hFF, o_frame_tick=0.
REQ-023 Reset asserted mid-slot shall darken the outputs asynchronously, within the same cycle.
- After release, scanning restarts at digit 0 with a fresh snapshot.

Configuration
REQ-024 SSEG_SCAN_DIMMING_EN defined: a free-running PWM_BITS counter increments every cycle.
- The digit is lit only while the counter < snapshot bright, or always when bright is all-ones.
REQ-025 SSEG_SCAN_DIMMING_EN undefined: i_bright is ignored, no PWM counter is built, and the digit is lit for the whole slot except the dead-time cycle.

Structure
REQ-026 Package sseg_pkg shall hold the segment-pattern typedef (8-bit, active-low), the SSEG_OFF constant 8'hFF, and the hex glyph table.
REQ-027 One sub-module, sseg_glyph_dec, shall map 4-bit hex plus dp to the active-low 8-bit pattern (purely combinational); all sequencing stays in sseg_scan_mux.

Verification (N_DIGITS=4, SCAN_DIV=4, PWM_BITS=4, dimming on unless stated)
REQ-028 Scan order: hex=16'h1234, bright=F.
- Expect o_ldsel 0001, 0010, 0100, 1000, each lit 3 cycles after 1 dead cycle, repeating.
- Expect glyphs 4, 3, 2, 1 with o_sseg_n of digit 0 = 8'h99.
REQ-029 LZS: hex=16'h0050, lzs=1.
- Expect digits 3 and 2 at 8'hFF, digit 1 showing 5, digit 0 showing 0 (8'hC0).
- Setting dp[3]=1 shall instead show digit 3 as 0 with dp lit (8'h40).
REQ-030 Frame coherency: change hex from 1234 to ABCD while digit 1 is active.
- Digits 2 and 3 shall still show 2 and 1 in that frame.
- ABCD shall appear from the next digit 0 onward, coincident with o_frame_tick.
REQ-031 Dimming: bright=4.
- The lit digit shall be active for 4 of every 16 cycles on the PWM counter.
- bright=0 shall give all-dark; with the macro undefined, bright=0 shall still light fully.
REQ-032 Reset: assert i_reset mid-slot of digit 2.
- Outputs dark the same cycle.
- After release, digit 0 is shown first, with o_frame_tick pulsing once.
